cpu_rf_scan: RTL
================

CPU_RF_SCAN -- requirements
Module: cpu_rf_scan

Interface
REQ-001 Parameter: DATA_W, 16, width of register data and out_data.
REQ-002 Parameter: NUM_REGS, 8, registers scanned (legal 1..8), indices 0..NUM_REGS-1.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port: start  in  1  scan request, honoured only in IDLE.
REQ-006 Port: abort  in  1  terminate scan in progress.
REQ-007 Port: reg_sel  out  3  register-file read select, drives the RF asynchronous read port.
REQ-008 Port: reg_data  in  DATA_W  RF read data for reg_sel (combinational return).
REQ-009 Port: out_valid  out  1  out_data/out_idx/out_last valid.
REQ-010 Port: out_ready  in  1  downstream accepts word when high with out_valid.
REQ-011 Port: out_data  out  DATA_W  streamed word.
REQ-012 Port: out_idx  out  3  register index of out_data.
REQ-013 Port: out_last  out  1  final word of the scan.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse at normal scan completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND, CHK, DONE.
REQ-017 IDLE: start=1 -> idx<=0, next FETCH; start ignored in all other states.
REQ-018 reg_sel SHALL equal registered idx in every state.
REQ-019 FETCH (one cycle): out_data<=reg_data, out_idx<=idx, out_valid<=1, out_last<=(idx==NUM_REGS-1 and no checksum word), next SEND.
REQ-020 Latency: start cycle N -> out_valid high at N+2 with R0 contents sampled at N+1.
REQ-021 SEND: out_valid, out_data, out_idx, out_last held stable until out_valid&&out_ready.
REQ-022 SEND handshake, idx<NUM_REGS-1: idx<=idx+1, out_valid<=0, next FETCH (one-cycle bubble per word).
REQ-023 SEND handshake, idx==NUM_REGS-1: out_valid<=0, next CHK if checksum compiled in, else DONE.
REQ-024 Each word SHALL reflect RF contents at its own FETCH cycle; concurrent RF writes to not-yet-fetched registers are visible.
REQ-025 DONE (one cycle): done=1, next IDLE; start in DONE ignored.
REQ-026 abort=1 in FETCH/SEND/CHK/DONE: next IDLE, out_valid<=0, out_last<=0, no done pulse; abort outranks a coincident handshake.
REQ-027 abort in IDLE SHALL have no effect; abort and start together in IDLE: start wins.
REQ-028 idx SHALL never exceed NUM_REGS-1; NUM_REGS=1 sends single word with out_last=1.

Reset
REQ-029 reset=0 at posedge clk: state IDLE, idx=0, reg_sel=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, checksum=0.
REQ-030 reset mid-scan SHALL discard the scan without done pulse; reset dominates start and abort.

Configuration
REQ-031 Macro CPU_RF_SCAN_CHKSUM_EN: when defined, a 16-bit modulo-2^16 running sum of all sent register words (cleared at start) SHALL be appended.
REQ-032 With macro: CHK state presents sum with out_idx=0, out_last=1, held until handshake, then DONE; register words have out_last=0.
REQ-033 Without macro: no CHK state, no sum register; last register word carries out_last=1.

Verification
REQ-034 RF R0..R7=0x1000..0x1007, out_ready=1, start pulse -> 8 words 0x1000..0x1007, out_idx 0..7, out_valid first at start+2, done pulse after last handshake.
REQ-035 Same data, out_ready low 3 cycles during word 2 -> out_data=0x1002 stable throughout, no word lost/duplicated.
REQ-036 Macro defined, R0..R7=0xFFFF -> ninth word 0xFFF8, out_last=1 only on it.
REQ-037 abort asserted during SEND of word 4 with out_ready=1 -> word 4 not counted, IDLE next cycle, out_valid=0, no done.
REQ-038 reset=0 during word 5 with start=1 held -> all outputs 0 next cycle; after release start re-scans from idx 0.
REQ-039 RF write R6=0xBEEF during word 2 -> streamed word 6 equals 0xBEEF.

Source files
------------

// File: rtl/cpu_rf_scan.sv
// Register-file scanner: streams R0..R(NUM_REGS-1) over valid/ready, one word every two cycles (FETCH then SEND).
// Optional build macro CPU_RF_SCAN_CHKSUM_EN appends a 16-bit modulo-2^16 sum of the sent words as a final word.
module cpu_rf_scan #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [2:0]        reg_sel_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [2:0]        out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

`ifdef CPU_RF_SCAN_CHKSUM_EN
    localparam bit HAS_CHK = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CHK, S_DONE} state_t;
    logic [15:0] sum_q;
`else
    localparam bit HAS_CHK = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
`endif

    state_t            state_q;
    logic [2:0]        idx_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [2:0]        out_idx_q;
    logic              out_last_q;
    logic              done_q;
    logic              handshake;

    assign handshake = out_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef CPU_RF_SCAN_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            // Abort outranks any coincident handshake and never produces a done pulse.
            if (abort_i && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            idx_q   <= '0;
                            state_q <= S_FETCH;
`ifdef CPU_RF_SCAN_CHKSUM_EN
                            sum_q   <= '0;
`endif
                        end
                    end
                    S_FETCH: begin
                        out_data_q  <= reg_data_i;
                        out_idx_q   <= idx_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (idx_q == LAST_IDX) && !HAS_CHK;
                        state_q     <= S_SEND;
                    end
                    S_SEND: begin
                        if (handshake) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
`ifdef CPU_RF_SCAN_CHKSUM_EN
                            sum_q       <= sum_q + 16'(out_data_q);
`endif
                            if (idx_q != LAST_IDX) begin
                                idx_q   <= idx_q + 3'd1;
                                state_q <= S_FETCH;
                            end else begin
`ifdef CPU_RF_SCAN_CHKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef CPU_RF_SCAN_CHKSUM_EN
                    S_CHK: begin
                        // First CHK cycle loads the sum; it is then held until accepted.
                        if (!out_valid_q) begin
                            out_data_q  <= DATA_W'(sum_q);
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else if (out_ready_i) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                        end
                    end
`endif
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign reg_sel_o   = idx_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule
